sum_tree_pipe: RTL and testbench

//  Pipelined, parametrised multi-operand adder: sums NUM_IN unsigned/signed WIDTH-bit operands plus a carry-in,

---
 rtl/sum_tree_pkg.sv | 38 +++
 rtl/sum_tree_node.sv | 49 ++++
 rtl/sum_tree_pipe.sv | 120 ++++++++++++
 tb/tb_sum_tree_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sum_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module : sum_tree_pkg
// Brief  : Shared sizing helpers for the pipelined multi-operand adder tree:
//          ceil-log2, result width, tree depth and per-level node count.
// Rev    : 1.0  initial release
// ============================================================================
package sum_tree_pkg;

    // Smallest r with 2**r >= n. The loop bound is fixed so it elaborates as a constant.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // The result width must hold NUM_IN*(2**WIDTH-1) + 1 (the +1 is the carry-in).
    function automatic int calc_ow(input int width, input int num_in);
        return width + clog2_f(num_in + 1);
    endfunction

    // Tree depth, which is also the latency in cycles.
    function automatic int calc_levels(input int num_in);
        return clog2_f(num_in);
    endfunction

    // Number of live nodes at a level: ceil(n / 2**level). Level 0 is the operand row.
    function automatic int nodes_at(input int level, input int n);
        return (n + (1 << level) - 1) >> level;
    endfunction

endpackage : sum_tree_pkg
`default_nettype wire

// File: rtl/sum_tree_node.sv
`default_nettype none
// ============================================================================
// Module : sum_tree_node
// Brief  : One registered node of the adder tree. It adds two OW-bit values
//          plus an optional carry-in. When BYPASS is set, it forwards operand
//          a as the odd leftover of a level. It holds its value when en is low.
// Rev    : 1.0  initial release
// ============================================================================
module sum_tree_node #(
    parameter int OW     = 8,
    parameter bit BYPASS = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [OW-1:0] a,
    input  logic [OW-1:0] b,
    input  logic          cin,
    output logic [OW-1:0] sum_q
);

    logic [OW-1:0] w_b_eff;
    logic [OW-1:0] w_cin_ext;
    logic [OW-1:0] sum_d;

    // An odd leftover has no partner, so b is forced to zero.
    // The value then passes through the register unchanged, apart from cin.
    assign w_b_eff   = BYPASS ? '0 : b;
    assign w_cin_ext = {{(OW-1){1'b0}}, cin};

    // Next-state: load the new partial sum when the pipeline advances, otherwise hold.
    always_comb begin
        sum_d = sum_q;
        if (en) begin
            sum_d = a + w_b_eff + w_cin_ext;
        end
    end

    // Node register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

endmodule : sum_tree_node
`default_nettype wire

// File: rtl/sum_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module : sum_tree_pipe
// Brief  : Pipelined NUM_IN-operand adder with carry-in and optional output
//          inversion. It is a registered binary tree of LEVELS stages behind
//          valid/ready handshakes. The whole pipe shares a single advance
//          enable, so a stalled consumer freezes every stage in place.
// Rev    : 1.0  initial release
// ============================================================================
module sum_tree_pipe
    import sum_tree_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 5,
    parameter  bit SIGNED = 1'b0,
    localparam int OW     = calc_ow(WIDTH, NUM_IN),
    localparam int LEVELS = calc_levels(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_cin,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OW-1:0]           out_sum
);

    // Tree rows. Row 0 holds the extended operands; row l holds the outputs of the level-l nodes.
    // Slots beyond a row's live node count are tied to zero.
    logic [OW-1:0]     w_tree [LEVELS+1][NUM_IN];
    logic              w_adv;

    // Sideband shift chain that travels alongside the data. Stage i matches tree row i+1.
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] inv_q;
    logic [LEVELS-1:0] inv_d;

    // The pipe advances unless a valid result is blocked by the consumer.
    // in_ready therefore has no path from in_valid.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Row 0: widen each operand to OW bits, with sign extension or zero extension.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_operand
        logic [WIDTH-1:0] w_op;
        assign w_op = in_data[k*WIDTH +: WIDTH];
        if (SIGNED) begin : g_sext
            assign w_tree[0][k] = {{(OW-WIDTH){w_op[WIDTH-1]}}, w_op};
        end else begin : g_zext
            assign w_tree[0][k] = {{(OW-WIDTH){1'b0}}, w_op};
        end
    end

    // Levels 1..LEVELS: each node combines entries 2j and 2j+1 of the previous row.
    // An odd last entry is bypassed. The carry-in enters only at pair 0 of level 1.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        for (genvar j = 0; j < NUM_IN; j++) begin : g_slot
            if (j < nodes_at(l, NUM_IN)) begin : g_node
                localparam bit IS_ODD = ((2*j + 1) >= nodes_at(l - 1, NUM_IN));
                localparam int B_IDX  = IS_ODD ? (2*j) : (2*j + 1);
                logic w_node_cin;
                if ((l == 1) && (j == 0)) begin : g_cin
                    assign w_node_cin = in_cin;
                end else begin : g_nocin
                    assign w_node_cin = 1'b0;
                end
                sum_tree_node #(
                    .OW     (OW),
                    .BYPASS (IS_ODD)
                ) u_node (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (w_adv),
                    .a     (w_tree[l-1][2*j]),
                    .b     (w_tree[l-1][B_IDX]),
                    .cin   (w_node_cin),
                    .sum_q (w_tree[l][j])
                );
            end else begin : g_empty
                assign w_tree[l][j] = '0;
            end
        end
    end

    // Sideband next-state: shift valid and inv one stage on advance, hold on stall.
    // Bubbles shift exactly like data.
    always_comb begin
        valid_d = valid_q;
        inv_d   = inv_q;
        if (w_adv) begin
            valid_d[0] = in_valid;
            inv_d[0]   = in_inv;
            for (int i = 1; i < LEVELS; i++) begin
                valid_d[i] = valid_q[i-1];
                inv_d[i]   = inv_q[i-1];
            end
        end
    end

    // Sideband registers. Reset drops every in-flight bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            inv_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inv_q   <= inv_d;
        end
    end

    // Output: last-stage valid, and the root sum, optionally inverted by the bundle's own flag.
    assign out_valid = valid_q[LEVELS-1];
    assign out_sum   = inv_q[LEVELS-1] ? ~w_tree[LEVELS][0] : w_tree[LEVELS][0];

endmodule : sum_tree_pipe
`default_nettype wire

// File: tb/tb_sum_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_sum_tree_pipe
// Brief  : Directed self-checking bench for sum_tree_pipe. It covers three
//          instances: the default 5x8 unsigned pipe, a 3x4 signed pipe and a
//          2x1 add2-equivalent pipe.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sum_tree_pipe;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=8, NUM_IN=5, unsigned -> OW=11, LEVELS=3
    logic        a_in_valid, a_in_ready, a_in_cin, a_in_inv, a_out_valid, a_out_ready;
    logic [39:0] a_in_data;
    logic [10:0] a_out_sum;

    // Instance B: WIDTH=4, NUM_IN=3, signed -> OW=6, LEVELS=2
    logic        b_in_valid, b_in_ready, b_in_cin, b_in_inv, b_out_valid, b_out_ready;
    logic [11:0] b_in_data;
    logic [5:0]  b_out_sum;

    // Instance C: WIDTH=1, NUM_IN=2, unsigned -> OW=3, LEVELS=1
    logic        c_in_valid, c_in_ready, c_in_cin, c_in_inv, c_out_valid, c_out_ready;
    logic [1:0]  c_in_data;
    logic [2:0]  c_out_sum;

    int n_checks = 0;
    int n_errors = 0;

    sum_tree_pipe #(.WIDTH(8), .NUM_IN(5), .SIGNED(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_cin(a_in_cin), .in_inv(a_in_inv),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum)
    );

    sum_tree_pipe #(.WIDTH(4), .NUM_IN(3), .SIGNED(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_cin(b_in_cin), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum)
    );

    sum_tree_pipe #(.WIDTH(1), .NUM_IN(2), .SIGNED(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_cin(c_in_cin), .in_inv(c_in_inv),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          n_acc;
        int          n_out;
        logic        prev_stall;
        logic [10:0] prev_sum;
        logic        ra, rb, rc, ri;
        logic [2:0]  s3;
        logic [2:0]  c_exp;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_cin = 1'b0; a_in_inv = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
        b_in_valid = 1'b0; b_in_cin = 1'b0; b_in_inv = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
        c_in_valid = 1'b0; c_in_cin = 1'b0; c_in_inv = 1'b0; c_out_ready = 1'b1; c_in_data = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_a_out_valid", a_out_valid, 0);
        check_eq("rst_a_out_sum",   a_out_sum,   0);
        check_eq("rst_a_in_ready",  a_in_ready,  1);
        check_eq("rst_b_out_valid", b_out_valid, 0);
        check_eq("rst_c_out_valid", c_out_valid, 0);
        rst_n = 1'b1;

        // ---------------- A: all 0xFF, cin=1 -> 0x4FC after 3 cycles ----------------
        a_in_valid = 1'b1; a_in_data = {5{8'hFF}}; a_in_cin = 1'b1; a_in_inv = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        check_eq("a_lat1_valid", a_out_valid, 0);
        @(negedge clk);
        check_eq("a_lat2_valid", a_out_valid, 0);
        @(negedge clk);
        check_eq("a_ff_valid", a_out_valid, 1);
        check_eq("a_ff_sum",   a_out_sum,   32'h4FC);

        // ---------------- A: inverted 0xFF bundle, then 1..5 back-to-back ----------------
        a_in_valid = 1'b1; a_in_data = {5{8'hFF}}; a_in_cin = 1'b1; a_in_inv = 1'b1;
        @(negedge clk);
        a_in_data = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; a_in_cin = 1'b0; a_in_inv = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        check_eq("a_inv_valid", a_out_valid, 1);
        check_eq("a_inv_sum",   a_out_sum,   32'h303);
        @(negedge clk);
        check_eq("a_b2b_valid", a_out_valid, 1);
        check_eq("a_b2b_sum",   a_out_sum,   15);
        @(negedge clk);
        check_eq("a_drain_valid", a_out_valid, 0);

        // ---------------- A: stream 10 bundles with out_ready toggling ----------------
        n_acc = 0; n_out = 0; prev_stall = 1'b0; prev_sum = '0;
        a_in_cin = 1'b0; a_in_inv = 1'b0;
        for (int cyc = 0; cyc < 200 && n_out < 10; cyc++) begin
            if (cyc != 0) @(negedge clk);
            a_out_ready = ((cyc % 2) == 0);
            a_in_valid  = (n_acc < 10);
            a_in_data   = {32'd0, n_acc[7:0]};
            #1;
            if (prev_stall) begin
                check_eq("stall_hold_valid", a_out_valid, 1);
                check_eq("stall_hold_sum",   a_out_sum,   prev_sum);
            end
            check_eq("stream_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
            if (a_out_valid && a_out_ready) begin
                check_eq("stream_order", a_out_sum, n_out);
                n_out++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_sum   = a_out_sum;
            if (a_in_valid && a_in_ready) n_acc++;
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        check_eq("stream_count",    n_out, 10);
        check_eq("stream_accepted", n_acc, 10);

        // ---------------- A: reset mid-flight drops bundles ----------------
        repeat (4) @(negedge clk);
        a_in_valid = 1'b1; a_in_data = {5{8'd1}}; a_in_cin = 1'b0;
        @(negedge clk);
        a_in_data = {5{8'd2}};
        @(negedge clk);
        a_in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_valid0", a_out_valid, 0);
        check_eq("midrst_sum0",   a_out_sum,   0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("midrst_valid_hold", a_out_valid, 0);
        end
        a_in_valid = 1'b1; a_in_data = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}; a_in_cin = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("postrst_valid", a_out_valid, 1);
        check_eq("postrst_sum",   a_out_sum,   151);

        // ---------------- B: signed -8 + -8 + 7 = -9 (6'h37), then inverted -> 6'h08 ----------------
        b_in_valid = 1'b1; b_in_data = {4'h7, 4'h8, 4'h8}; b_in_cin = 1'b0; b_in_inv = 1'b0;
        @(negedge clk);
        b_in_inv = 1'b1;
        check_eq("b_lat1_valid", b_out_valid, 0);
        @(negedge clk);
        b_in_valid = 1'b0;
        check_eq("b_signed_valid", b_out_valid, 1);
        check_eq("b_signed_sum",   b_out_sum,   32'h37);
        @(negedge clk);
        check_eq("b_signed_inv_sum", b_out_sum, 32'h08);

        // ---------------- C: add2 equivalent, 1+1+1 = 3, then 1000 random vs model ----------------
        c_in_valid = 1'b1; c_in_data = 2'b11; c_in_cin = 1'b1; c_in_inv = 1'b0;
        c_exp = 3'b011;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            check_eq((i == 0) ? "c_add2_111" : "c_rand", {c_out_valid, c_out_sum}, {1'b1, c_exp});
            if (i < 1000) begin
                ra = 1'($urandom_range(0, 1));
                rb = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                ri = 1'($urandom_range(0, 1));
                c_in_data = {rb, ra}; c_in_cin = rc; c_in_inv = ri;
                s3    = {2'b00, ra} + {2'b00, rb} + {2'b00, rc};
                c_exp = ri ? ~s3 : s3;
            end else begin
                c_in_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sum_tree_pipe
`default_nettype wire
